imem_loader: RTL

- Writer side of the instruction-memory port of the single-cycle core. The core itself only reads that memory; its write enable, address and data are tied off.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into ANCHO-bit words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset (cpu_rst_no) while a program is being loaded.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  localparam int ANCHO_DEF = 32;
  localparam int BYTES     = ANCHO_DEF / 8;

  // A one-byte word still needs a one-bit counter to keep port widths legal.
  function automatic int bcnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  localparam int BCNT_W = bcnt_width(BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer; word shows the lanes with the incoming byte merged in.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int NB    = BYTES,
  parameter int BW    = BCNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid,
  input  logic [7:0]       data,
  input  logic             clear,
  output logic [ANCHO-1:0] word,
  output logic             word_full
);

  logic [BW-1:0]    bcnt;
  logic [ANCHO-1:0] lanes;

  // Merging the current byte lets the owner latch a complete word on the last handshake.
  always_comb begin
    word = lanes;
    if (valid) word[8*bcnt +: 8] = data;
  end

  assign word_full = valid && !clear && (bcnt == BW'(NB - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt <= '0;
    end else if (clear) begin
      bcnt <= '0;
    end else if (valid) begin
      bcnt <= word_full ? '0 : bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (valid && !clear) lanes <= word;
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as packed words and holds the core in reset while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int PROF      = 8,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [PROF:0]    len_i,
  input  logic             abort_i,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  output logic             s_ready_o,
  output logic             wren_o,
  output logic [PROF-1:0]  wraddr_o,
  output logic [ANCHO-1:0] wrdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cpu_rst_no
);

  localparam int NB = ANCHO / 8;
  localparam int BW = bcnt_width(NB);
  localparam logic [PROF:0] DEPTH = (PROF+1)'(1) << PROF;
  localparam logic [PROF:0] ONE   = (PROF+1)'(1);

  function automatic logic [PROF:0] clamp_len(input logic [PROF:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  state_e           state;
  logic [PROF:0]    wcnt;
  logic [PROF:0]    len;
  logic [ANCHO-1:0] word;
  logic             word_full;
  logic             abort_act;

  assign abort_act = abort_i && (state != IDLE);

  imem_loader_byte_packer #(
    .ANCHO (ANCHO),
    .NB    (NB),
    .BW    (BW)
  ) u_packer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid     (s_valid_i && s_ready_o),
    .data      (s_data_i),
    .clear     (abort_act),
    .word      (word),
    .word_full (word_full)
  );

  // Outputs are registered on entry to each state so they are valid throughout it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      s_ready_o  <= 1'b0;
      wren_o     <= 1'b0;
      wraddr_o   <= '0;
      wrdata_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      cpu_rst_no <= !BOOT_HOLD;
      wcnt       <= '0;
      len        <= '0;
    end else begin
      wren_o <= 1'b0;
      if (abort_act) begin
        // The core stays held: an aborted image must never be executed.
        state      <= IDLE;
        s_ready_o  <= 1'b0;
        busy_o     <= 1'b0;
        done_o     <= 1'b0;
        cpu_rst_no <= 1'b0;
        wcnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              len  <= clamp_len(len_i);
              wcnt <= '0;
              if (len_i == '0) begin
                state      <= DONE;
                done_o     <= 1'b1;
                busy_o     <= 1'b0;
                cpu_rst_no <= 1'b1;
              end else begin
                state      <= COLLECT;
                s_ready_o  <= 1'b1;
                done_o     <= 1'b0;
                busy_o     <= 1'b1;
                cpu_rst_no <= 1'b0;
              end
            end
          end
          COLLECT: begin
            if (word_full) begin
              state     <= WRITE;
              s_ready_o <= 1'b0;
              wren_o    <= 1'b1;
              wraddr_o  <= wcnt[PROF-1:0];
              wrdata_o  <= word;
            end
          end
          WRITE: begin
            wcnt <= wcnt + ONE;
            if (wcnt + ONE == len) begin
              state      <= DONE;
              done_o     <= 1'b1;
              busy_o     <= 1'b0;
              cpu_rst_no <= 1'b1;
            end else begin
              state     <= COLLECT;
              s_ready_o <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
